// File: rtl/sum_pkg.sv
// Shared constants, state encoding and slice-count helper for the serial adder.
package sum_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned n_slices(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/sum_4bits_c.sv
// Combinational 4-bit adder slice with carry in/out.
module sum_4bits_c
    import sum_pkg::*;
(
    input  logic               cin,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic [SLICE_W-1:0] f,
    output logic               cout
);

    localparam int unsigned SUM_W = SLICE_W + 1;

    always_comb begin
        {cout, f} = {1'b0, a} + {1'b0, b} + SUM_W'(cin);
    end

endmodule

// File: rtl/sum_serial_ctrl.sv
// Serial WIDTH-bit adder reusing one 4-bit slice, LS nibble first.
// Define SUM_CARRY_OUT_EN to expose the registered final carry on c_out.
module sum_serial_ctrl
    import sum_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f
`ifdef SUM_CARRY_OUT_EN
    ,
    output logic             c_out
`endif
);

    localparam int unsigned N_SLICES = n_slices(WIDTH);
    localparam int unsigned IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   f_q, f_d;
`ifdef SUM_CARRY_OUT_EN
    logic               cout_q, cout_d;
`endif

    logic [SLICE_W-1:0] slice_a, slice_b, slice_f;
    logic               slice_co;

    sum_4bits_c u_slice (
        .cin  (carry_q),
        .a    (slice_a),
        .b    (slice_b),
        .f    (slice_f),
        .cout (slice_co)
    );

    // Operand nibble select for the current slice index.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < N_SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            f_q     <= '0;
`ifdef SUM_CARRY_OUT_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            f_q     <= f_d;
`ifdef SUM_CARRY_OUT_EN
            cout_q  <= cout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        f_d     = f_q;
`ifdef SUM_CARRY_OUT_EN
        cout_d  = cout_q;
`endif
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                for (int unsigned i = 0; i < N_SLICES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        acc_d[i*SLICE_W +: SLICE_W] = slice_f;
                    end
                end
                carry_d = slice_co;
                idx_d   = idx_q + IDX_W'(1);
                // Last slice: publish the completed accumulator.
                if (idx_q == IDX_W'(N_SLICES - 1)) begin
                    f_d     = acc_d;
`ifdef SUM_CARRY_OUT_EN
                    cout_d  = slice_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign f = f_q;
`ifdef SUM_CARRY_OUT_EN
    assign c_out = cout_q;
`endif

endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Directed self-checking bench for sum_serial_ctrl (WIDTH=16).
module tb_sum_serial_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
`ifdef SUM_CARRY_OUT_EN
    logic             c_out;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] prev_f;

    sum_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .f     (f)
`ifdef SUM_CARRY_OUT_EN
        ,
        .c_out (c_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE; operands are scrambled right after sampling.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] exp_f,
                          input logic exp_c);
        check({tag, ".ready_idle"}, 32'(ready), 32'd1);
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a = ~av;
        b = 16'h5A5A;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".ready_add"}, 32'(ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check({tag, ".no_done_add"}, 32'(done), 32'd0);
            check({tag, ".f_hold"}, 32'(f), 32'(prev_f));
        end
        step();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".f"}, 32'(f), 32'(exp_f));
`ifdef SUM_CARRY_OUT_EN
        check({tag, ".c_out"}, 32'(c_out), 32'(exp_c));
`else
        if (exp_c !== exp_c) n_cmp = n_cmp;
`endif
        prev_f = exp_f;
        step();
        check({tag, ".done_low"}, 32'(done), 32'd0);
        check({tag, ".ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int snap;
        logic [WIDTH-1:0] bb_a [3];
        logic [WIDTH-1:0] bb_b [3];
        logic [WIDTH-1:0] bb_f [3];
        logic             bb_c [3];

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        prev_f = '0;
        #2;
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.f", 32'(f), 32'd0);
`ifdef SUM_CARRY_OUT_EN
        check("rst.c_out", 32'(c_out), 32'd0);
`endif
        step();
        step();
        rst = 1'b0;
        step();

        run_op("basic", 16'h0003, 16'h0008, 16'h000B, 1'b0);
        run_op("carry8", 16'h00FF, 16'h0001, 16'h0100, 1'b0);
        run_op("carry12", 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
        run_op("wrap", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("mix", 16'h8421, 16'h7BDE, 16'hFFFF, 1'b0);

        // Start pulsed during ADD must be ignored.
        snap = done_cnt;
        a = 16'h0007;
        b = 16'h0004;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 16'h1111;
        b = 16'h1111;
        start = 1'b1;
        step();
        check("busy_start.busy", 32'(busy), 32'd1);
        start = 1'b0;
        step();
        step();
        check("busy_start.done", 32'(done), 32'd1);
        check("busy_start.f", 32'(f), 32'h000B);
        prev_f = 16'h000B;
        repeat (8) step();
        check("busy_start.one_done", 32'(done_cnt - snap), 32'd1);
        check("busy_start.idle", 32'(ready), 32'd1);

        // Reset asserted in the second ADD cycle aborts the operation.
        snap = done_cnt;
        a = 16'h0005;
        b = 16'h0005;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid.ready", 32'(ready), 32'd1);
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.f", 32'(f), 32'd0);
        step();
        step();
        rst = 1'b0;
        prev_f = '0;
        repeat (8) step();
        check("rst_mid.no_done", 32'(done_cnt - snap), 32'd0);
        check("rst_mid.f_after", 32'(f), 32'd0);
        run_op("post_rst", 16'h1234, 16'h4321, 16'h5555, 1'b0);

        // Start held high: a new operation every 6 cycles.
        bb_a[0] = 16'hAAAA; bb_b[0] = 16'h5555; bb_f[0] = 16'hFFFF; bb_c[0] = 1'b0;
        bb_a[1] = 16'h8000; bb_b[1] = 16'h8000; bb_f[1] = 16'h0000; bb_c[1] = 1'b1;
        bb_a[2] = 16'h1234; bb_b[2] = 16'h0FED; bb_f[2] = 16'h2221; bb_c[2] = 1'b0;
        snap = done_cnt;
        start = 1'b1;
        a = bb_a[0];
        b = bb_b[0];
        for (int k = 0; k < 3; k++) begin
            check("b2b.ready", 32'(ready), 32'd1);
            step();
            if (k < 2) begin
                a = bb_a[k+1];
                b = bb_b[k+1];
            end else begin
                start = 1'b0;
            end
            repeat (3) step();
            check("b2b.no_done", 32'(done), 32'd0);
            step();
            check("b2b.done", 32'(done), 32'd1);
            check("b2b.f", 32'(f), 32'(bb_f[k]));
`ifdef SUM_CARRY_OUT_EN
            check("b2b.c_out", 32'(c_out), 32'(bb_c[k]));
`endif
            step();
        end
        repeat (4) step();
        check("b2b.done_count", 32'(done_cnt - snap), 32'd3);
        check("b2b.idle", 32'(ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
